// File: rtl/decoder_n_scan.sv
// -----------------------------------------------------------------------------
// decoder_n_scan
//
// Registered N-to-2**N one-hot decoder with chip-select gating. It can also
// auto-scan: the asserted output bit walks upward from a start address and
// dwells DIV clock cycles on each value.
//
// Build option:
//   DECODER_N_SCAN_SCAN_EN  - when defined, the auto-scan logic is compiled in.
//                             When undefined, i_mode is ignored, o_wrap is
//                             tied low, and the block is a plain registered
//                             decoder.
//
// Parameters:
//   N    - address width (1..6); the output is 2**N bits wide
//   DIV  - clock cycles spent on each scan step (1..65535)
//
// Ports:
//   clk     - single clock, rising edge
//   rst_n   - asynchronous active-low reset
//   i_a     - static address, or scan start index on scan entry
//   i_cs    - chip select; the block is enabled only when i_cs == 3'b110
//   i_mode  - 0 = static decode, 1 = auto-scan
//   o_y     - registered one-hot decode, active high
//   o_idx   - registered index of the asserted o_y bit
//   o_wrap  - one-cycle pulse when the scan wraps from 2**N-1 to 0
// -----------------------------------------------------------------------------
module decoder_n_scan #(
   parameter int N   = 3,
   parameter int DIV = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    i_a,
   input  logic [2:0]      i_cs,
   input  logic            i_mode,
   output logic [2**N-1:0] o_y,
   output logic [N-1:0]    o_idx,
   output logic            o_wrap
);

   localparam int         W      = 2**N;
   localparam logic [2:0] CS_EN  = 3'b110;

   logic          w_en;
   logic [W-1:0]  r_y;
   logic [N-1:0]  r_idx;

   assign w_en = (i_cs == CS_EN);

   function automatic logic [W-1:0] onehot(input logic [N-1:0] v);
      onehot    = '0;
      onehot[v] = 1'b1;
   endfunction

`ifdef DECODER_N_SCAN_SCAN_EN

   localparam int            PW         = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [N-1:0]  IDX_LAST   = N'(W - 1);

   // S_IDLE covers static decode and the disabled state; leaving S_SCAN for
   // either one makes the next enabled mode=1 sample a fresh scan entry.
   typedef enum logic {
      S_IDLE,
      S_SCAN
   } state_t;

   state_t         r_state;
   logic [PW-1:0]  r_presc;
   logic [N-1:0]   r_scan_idx;
   logic           r_wrap;
   logic [N-1:0]   w_next_idx;

   // Natural N-bit overflow provides the modulo-2**N wrap.
   assign w_next_idx = r_scan_idx + N'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: reset is asynchronous, so the outputs clear (and any scan in
         // progress is abandoned) without waiting for a clock edge.
         r_state    <= S_IDLE;
         r_presc    <= '0;
         r_scan_idx <= '0;
         r_y        <= '0;
         r_idx      <= '0;
         r_wrap     <= 1'b0;
      end else if (!w_en) begin
         // Disabled: blank the output, freeze index and prescaler.
         r_state <= S_IDLE;
         r_y     <= '0;
         r_wrap  <= 1'b0;
      end else if (i_mode) begin
         if (r_state != S_SCAN) begin
            // Scan entry: restart from the current address.
            r_state    <= S_SCAN;
            r_presc    <= '0;
            r_scan_idx <= i_a;
            r_y        <= onehot(i_a);
            r_idx      <= i_a;
            r_wrap     <= 1'b0;
         end else if (r_presc == PRESC_LAST) begin
            r_presc    <= '0;
            r_scan_idx <= w_next_idx;
            r_y        <= onehot(w_next_idx);
            r_idx      <= w_next_idx;
            r_wrap     <= (r_scan_idx == IDX_LAST);
         end else begin
            r_presc <= r_presc + PW'(1);
            r_wrap  <= 1'b0;
         end
      end else begin
         // Static decode; the scan index is left alone since re-entry
         // reloads it from i_a anyway.
         r_state <= S_IDLE;
         r_presc <= '0;
         r_y     <= onehot(i_a);
         r_idx   <= i_a;
         r_wrap  <= 1'b0;
      end
   end

   assign o_wrap = r_wrap;

`else

   // Scan is not built: mode has no effect.
   logic w_unused_mode;
   assign w_unused_mode = i_mode;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y   <= '0;
         r_idx <= '0;
      end else if (!w_en) begin
         r_y <= '0;
      end else begin
         r_y   <= onehot(i_a);
         r_idx <= i_a;
      end
   end

   assign o_wrap = 1'b0;

`endif

   assign o_y   = r_y;
   assign o_idx = r_idx;

endmodule
